// File: rtl/gba_eeprom_ctrl.sv
// GBA bit-serial EEPROM responder driving the 1-bit port A of the save BRAM.
// Optional post-write busy period is enabled with `define GBA_EEPROM_BUSY_EN.
module gba_eeprom_ctrl #(
    parameter int ADDR_BITS   = 14,
    parameter int BUSY_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        we,
    input  logic        wbit,
    output logic        ack,
    output logic        rbit,
    output logic [15:0] mem_ada,
    output logic        mem_dina,
    input  logic        mem_douta,
    output logic        mem_cea,
    output logic        mem_wrea,
    output logic        dirty,
    input  logic        dirty_clr
);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA, S_WSTOP, S_RSTOP, S_RDUMMY, S_RDATA, S_BUSY
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [9:0]  block_q, block_d;
    logic        rd_cmd_q, rd_cmd_d;
    logic        ack_q, ack_d;
    logic        rbit_q, rbit_d;
    logic        rd_pend_q, rd_pend_d;
    logic        rd_val_q, rd_val_d;
    logic        rd_mem_q, rd_mem_d;
    logic        rsel_q, rsel_d;
    logic        cea_q, cea_d;
    logic        wrea_q, wrea_d;
    logic [15:0] ada_q, ada_d;
    logic        dina_q, dina_d;
    logic        dirty_q, dirty_d;
    logic        accept;
    logic        wr_set;
`ifdef GBA_EEPROM_BUSY_EN
    localparam int BUSY_W = $clog2(BUSY_CYCLES + 1);
    logic [BUSY_W-1:0] busy_q, busy_d;
`endif

    // One access in flight at a time: a read occupies two cycles, a write one.
    assign accept = req && !rd_pend_q && !ack_q;

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        block_d   = block_q;
        rd_cmd_d  = rd_cmd_q;
        ack_d     = rd_pend_q;
        rbit_d    = rd_pend_q ? rd_val_q : rbit_q;
        rsel_d    = rd_mem_q;
        rd_pend_d = 1'b0;
        rd_val_d  = rd_val_q;
        rd_mem_d  = 1'b0;
        cea_d     = 1'b0;
        wrea_d    = 1'b0;
        ada_d     = ada_q;
        dina_d    = dina_q;
        wr_set    = 1'b0;
`ifdef GBA_EEPROM_BUSY_EN
        busy_d    = busy_q;
`endif
        if (accept) begin
            if (we) begin
                ack_d = 1'b1;
            end else begin
                rd_pend_d = 1'b1;
                rd_val_d  = 1'b0;
            end
        end

        unique case (state_q)
            S_IDLE: if (accept) begin
                if (we && wbit) state_d = S_CMD;
                else if (!we)   rd_val_d = 1'b1;
            end
            S_CMD: if (accept && we) begin
                rd_cmd_d = wbit;
                cnt_d    = '0;
                block_d  = '0;
                state_d  = S_ADDR;
            end
            // A 10-bit shift register keeps the low 10 address bits and zero-extends short addresses.
            S_ADDR: if (accept && we) begin
                block_d = {block_q[8:0], wbit};
                if (cnt_q == 6'(ADDR_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = rd_cmd_q ? S_RSTOP : S_WDATA;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_WDATA: if (accept && we) begin
                cea_d   = 1'b1;
                wrea_d  = 1'b1;
                ada_d   = {block_q, cnt_q[5:3], ~cnt_q[2:0]};
                dina_d  = wbit;
                wr_set  = 1'b1;
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == 6'd63) state_d = S_WSTOP;
            end
            S_WSTOP: if (accept && we) begin
`ifdef GBA_EEPROM_BUSY_EN
                busy_d  = BUSY_W'(BUSY_CYCLES - 1);
                state_d = S_BUSY;
`else
                state_d = S_IDLE;
`endif
            end
            S_RSTOP: if (accept && we) begin
                cnt_d   = '0;
                state_d = S_RDUMMY;
            end
            S_RDUMMY: if (accept) begin
                if (we) begin
                    state_d = wbit ? S_CMD : S_IDLE;
                end else if (cnt_q == 6'd3) begin
                    cnt_d   = '0;
                    state_d = S_RDATA;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_RDATA: if (accept) begin
                if (we) begin
                    state_d = wbit ? S_CMD : S_IDLE;
                end else begin
                    cea_d    = 1'b1;
                    ada_d    = {block_q, cnt_q[5:3], ~cnt_q[2:0]};
                    rd_mem_d = 1'b1;
                    cnt_d    = cnt_q + 6'd1;
                    if (cnt_q == 6'd63) state_d = S_IDLE;
                end
            end
            S_BUSY: begin
`ifdef GBA_EEPROM_BUSY_EN
                if (busy_q == '0) state_d = S_IDLE;
                else              busy_d  = busy_q - 1'b1;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Set wins over a simultaneous clear.
        dirty_d = wr_set | (dirty_q & ~dirty_clr);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            block_q   <= '0;
            rd_cmd_q  <= 1'b0;
            ack_q     <= 1'b0;
            rbit_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_val_q  <= 1'b0;
            rd_mem_q  <= 1'b0;
            rsel_q    <= 1'b0;
            cea_q     <= 1'b0;
            wrea_q    <= 1'b0;
            ada_q     <= '0;
            dina_q    <= 1'b0;
            dirty_q   <= 1'b0;
`ifdef GBA_EEPROM_BUSY_EN
            busy_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            block_q   <= block_d;
            rd_cmd_q  <= rd_cmd_d;
            ack_q     <= ack_d;
            rbit_q    <= rbit_d;
            rd_pend_q <= rd_pend_d;
            rd_val_q  <= rd_val_d;
            rd_mem_q  <= rd_mem_d;
            rsel_q    <= rsel_d;
            cea_q     <= cea_d;
            wrea_q    <= wrea_d;
            ada_q     <= ada_d;
            dina_q    <= dina_d;
            dirty_q   <= dirty_d;
`ifdef GBA_EEPROM_BUSY_EN
            busy_q    <= busy_d;
`endif
        end
    end

    // Data reads return the BRAM output directly, as it lands in the ack cycle.
    assign rbit     = rsel_q ? mem_douta : rbit_q;
    assign ack      = ack_q;
    assign mem_cea  = cea_q;
    assign mem_wrea = wrea_q;
    assign mem_ada  = ada_q;
    assign mem_dina = dina_q;
    assign dirty    = dirty_q;

endmodule

// File: tb/tb_gba_eeprom_ctrl.sv
// Directed bench for gba_eeprom_ctrl: a 14-bit and a 6-bit address instance, each with
// its own BRAM model; port-B bytes are rebuilt from the model bit array.
module tb_gba_eeprom_ctrl;

    logic clk = 1'b0;
    logic resetn, req, we, wbit, dirty_clr, sel;

    logic ack14, rbit14, dina14, douta14, cea14, wrea14, dirty14;
    logic ack6, rbit6, dina6, douta6, cea6, wrea6, dirty6;
    logic [15:0] ada14, ada6;
    logic req14, req6, ack_s, rbit_s;

    logic bram14 [0:65535];
    logic bram6  [0:65535];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign req14  = req & ~sel;
    assign req6   = req & sel;
    assign ack_s  = sel ? ack6 : ack14;
    assign rbit_s = sel ? rbit6 : rbit14;

    gba_eeprom_ctrl #(.ADDR_BITS(14), .BUSY_CYCLES(16)) u_dut14 (
        .clk(clk), .resetn(resetn), .req(req14), .we(we), .wbit(wbit),
        .ack(ack14), .rbit(rbit14), .mem_ada(ada14), .mem_dina(dina14),
        .mem_douta(douta14), .mem_cea(cea14), .mem_wrea(wrea14),
        .dirty(dirty14), .dirty_clr(dirty_clr)
    );

    gba_eeprom_ctrl #(.ADDR_BITS(6), .BUSY_CYCLES(16)) u_dut6 (
        .clk(clk), .resetn(resetn), .req(req6), .we(we), .wbit(wbit),
        .ack(ack6), .rbit(rbit6), .mem_ada(ada6), .mem_dina(dina6),
        .mem_douta(douta6), .mem_cea(cea6), .mem_wrea(wrea6),
        .dirty(dirty6), .dirty_clr(dirty_clr)
    );

    always @(posedge clk) begin
        if (cea14) begin
            if (wrea14) bram14[ada14] <= dina14;
            else        douta14 <= bram14[ada14];
        end
        if (cea6) begin
            if (wrea6) bram6[ada6] <= dina6;
            else       douta6 <= bram6[ada6];
        end
    end

    function automatic logic [7:0] byte14(input int k);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = bram14[k*8 + b];
        return v;
    endfunction

    function automatic logic [7:0] byte6(input int k);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = bram6[k*8 + b];
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus(input logic w, input logic b, input logic clr, output logic rb, output int lat);
        @(negedge clk);
        req = 1'b1; we = w; wbit = b; dirty_clr = clr;
        @(negedge clk);
        req = 1'b0; dirty_clr = 1'b0; lat = 1;
        while (!ack_s && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        rb = rbit_s;
    endtask

    task automatic wr(input logic b);
        logic rb;
        int   lat;
        bus(1'b1, b, 1'b0, rb, lat);
        check("write_ack_latency", lat, 1);
    endtask

    task automatic rd(output logic rb);
        int lat;
        bus(1'b0, 1'b0, 1'b0, rb, lat);
        check("read_ack_latency", lat, 2);
    endtask

    task automatic send_cmd(input logic is_rd, input logic [13:0] addr, input int nbits);
        wr(1'b1);
        wr(is_rd);
        for (int i = nbits - 1; i >= 0; i--) wr(addr[i]);
    endtask

    task automatic write_block(input logic [13:0] addr, input int nbits, input logic [63:0] d);
        send_cmd(1'b0, addr, nbits);
        for (int i = 63; i >= 0; i--) wr(d[i]);
        wr(1'b0);
    endtask

    task automatic read_block(input logic [13:0] addr, input int nbits, output logic [63:0] d);
        logic rb;
        logic [3:0] dummy;
        send_cmd(1'b1, addr, nbits);
        wr(1'b0);
        for (int i = 0; i < 4; i++) begin
            rd(rb);
            dummy[i] = rb;
        end
        check("read_dummy_bits", dummy, 4'h0);
        d = '0;
        for (int i = 0; i < 64; i++) begin
            rd(rb);
            d = {d[62:0], rb};
        end
    endtask

    typedef struct {
        logic we;
        logic wbit;
        logic exp_rbit;
        int   exp_lat;
    } vec_t;

    initial begin
        vec_t        vecs [7];
        logic        rb;
        int          lat;
        logic [63:0] d;
        logic [9:0]  part;
        logic [63:0] pat_a = 64'h0123456789ABCDEF;
        logic [63:0] pat_b = 64'hFEDCBA9876543210;
        logic [63:0] pat_c = 64'h1122334455667788;

        // Opening of a write command: IDLE reads, ignored 0, CMD and ADDR reads.
        vecs[0] = '{we: 1'b0, wbit: 1'b0, exp_rbit: 1'b1, exp_lat: 2};
        vecs[1] = '{we: 1'b1, wbit: 1'b0, exp_rbit: 1'b0, exp_lat: 1};
        vecs[2] = '{we: 1'b0, wbit: 1'b0, exp_rbit: 1'b1, exp_lat: 2};
        vecs[3] = '{we: 1'b1, wbit: 1'b1, exp_rbit: 1'b0, exp_lat: 1};
        vecs[4] = '{we: 1'b0, wbit: 1'b0, exp_rbit: 1'b0, exp_lat: 2};
        vecs[5] = '{we: 1'b1, wbit: 1'b0, exp_rbit: 1'b0, exp_lat: 1};
        vecs[6] = '{we: 1'b0, wbit: 1'b0, exp_rbit: 1'b0, exp_lat: 2};

        resetn = 1'b0; req = 1'b1; we = 1'b0; wbit = 1'b0; dirty_clr = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ack14", ack14, 0);
        check("reset_cea14", cea14, 0);
        check("reset_dirty14", dirty14, 0);
        check("reset_rbit14", rbit14, 0);
        check("reset_ada14", ada14, 0);
        check("reset_ack6", ack6, 0);
        check("reset_cea6", cea6, 0);
        req = 1'b0;
        resetn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            bus(vecs[i].we, vecs[i].wbit, 1'b0, rb, lat);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            if (!vecs[i].we) check($sformatf("vec%0d_rbit", i), rb, vecs[i].exp_rbit);
        end

        // Finish the write command: address 0x0003 and the 64-bit pattern.
        for (int i = 13; i >= 0; i--) wr(i < 2);
        for (int i = 63; i >= 0; i--) wr(pat_a[i]);
        wr(1'b0);
        for (int k = 0; k < 8; k++)
            check($sformatf("portb_byte_%0h", 8'h18 + k), byte14(8'h18 + k), pat_a[63 - 8*k -: 8]);
        check("dirty_after_write", dirty14, 1);

`ifdef GBA_EEPROM_BUSY_EN
        rd(rb);
        check("busy_read_zero", rb, 0);
        repeat (20) @(negedge clk);
        rd(rb);
        check("after_busy_read_one", rb, 1);
`else
        rd(rb);
        check("post_write_ready", rb, 1);
`endif

        @(negedge clk) dirty_clr = 1'b1;
        @(negedge clk) dirty_clr = 1'b0;
        check("dirty_cleared", dirty14, 0);

        read_block(14'h0003, 14, d);
        check("read_block3", d, pat_a);
        rd(rb);
        check("idle_after_read", rb, 1);

        // Abort a read at data bit 10 with a write 1, then run a write command.
        send_cmd(1'b1, 14'h0003, 14);
        wr(1'b0);
        for (int i = 0; i < 4; i++) rd(rb);
        for (int i = 0; i < 10; i++) begin
            rd(rb);
            part = {part[8:0], rb};
        end
        check("partial_read_bits", part, pat_a[63:54]);
        wr(1'b1);
        rd(rb);
        check("abort_lands_in_cmd", rb, 0);
        wr(1'b0);
        for (int i = 13; i >= 0; i--) wr(i == 10 || i == 2 || i == 0);
        check("dirty_before_data", dirty14, 0);
        bus(1'b1, pat_b[63], 1'b1, rb, lat);
        check("dirty_set_wins", dirty14, 1);
        for (int i = 62; i >= 0; i--) wr(pat_b[i]);
        wr(1'b0);
        check("block5_first_byte", byte14(8'h28), 8'hFE);
        check("block5_last_byte", byte14(8'h2F), 8'h10);
        check("block3_untouched", byte14(8'h18), 8'h01);
        read_block(14'h0005, 14, d);
        check("read_block5_wrapped", d, pat_b);

        // Reset in the middle of a write command.
        send_cmd(1'b0, 14'h0007, 14);
        for (int i = 0; i < 5; i++) wr(1'b1);
        @(negedge clk) resetn = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_ack", ack14, 0);
        check("midreset_cea", cea14, 0);
        resetn = 1'b1;
        @(negedge clk);
        check("midreset_no_write", cea14, 0);
        rd(rb);
        check("midreset_idle", rb, 1);

        // 6-bit address part, top block.
        sel = 1'b1;
        write_block(14'h003F, 6, pat_c);
        check("ada6_block", ada6[15:6], 10'h03F);
        check("ada6_last_offset", ada6[5:0], 6'h38);
        check("ada6_upper_zero", ada6[15:12], 4'h0);
        check("part6_first_byte", byte6(16'h1F8), 8'h11);
        check("part6_last_byte", byte6(16'h1FF), 8'h88);
        check("dirty6_set", dirty6, 1);
        read_block(14'h003F, 6, d);
        check("read6_block3f", d, pat_c);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
